// File: rtl/mult_share_ctrl_if.sv
// Purpose: handshake/data bundle between two multiplier clients and mult_share_ctrl.
// Latency: n/a (wiring only).
// Backpressure: n/a; req is a level held by the client until its grant pulse.
//
// Signals (client view):
//   req0/req1     request levels, held until the matching grant pulse
//   a0,b0/a1,b1   multiplicand / multiplier per client (SIZE bits)
//   grant0/1      one-cycle pulse: operands of that client captured
//   done0/1       one-cycle pulse: outcome belongs to that client
//   outcome       last completed product (2*SIZE bits), held between completions
//   busy          high while a product is being computed
interface mult_share_ctrl_if #(
  parameter int SIZE = 8
);
  logic              req0;
  logic [SIZE-1:0]   a0;
  logic [SIZE-1:0]   b0;
  logic              req1;
  logic [SIZE-1:0]   a1;
  logic [SIZE-1:0]   b1;
  logic              grant0;
  logic              grant1;
  logic              done0;
  logic              done1;
  logic [2*SIZE-1:0] outcome;
  logic              busy;

  // Client side: drives requests and operands, observes results.
  modport master (
    output req0, a0, b0, req1, a1, b1,
    input  grant0, grant1, done0, done1, outcome, busy
  );

  // Controller side.
  modport slave (
    input  req0, a0, b0, req1, a1, b1,
    output grant0, grant1, done0, done1, outcome, busy
  );
endinterface

// File: rtl/mult_share_ctrl.sv
// Purpose: round-robin arbiter + sequencer sharing one SIZE x SIZE shift-add multiplier between two clients.
// Latency: grant the cycle after the accept edge; done/outcome SIZE edges after accept; next accept one edge later.
// Backpressure: requests are ignored while busy; a held req is arbitrated at the first edge back in IDLE.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-low reset
//   bus    mult_share_ctrl_if.slave: req/a/b per client in; grant/done per client,
//          outcome and busy out (all outputs registered)
module mult_share_ctrl #(
  parameter int SIZE = 8,
  parameter int CW   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  mult_share_ctrl_if.slave      bus
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CALC = 1'b1
  } state_t;

  // Counter value on the edge that retires the last multiplier bit.
  localparam logic [CW-1:0] LAST_CNT = CW'(SIZE - 1);

  state_t              r_state;
  logic [2*SIZE-1:0]   r_temp_a;
  logic [SIZE-1:0]     r_temp_b;
  logic [2*SIZE-1:0]   r_acc;
  logic [2*SIZE-1:0]   r_outcome;
  logic [CW-1:0]       r_cnt;
  logic                r_owner;   // client whose job is in flight
  logic                r_rr;      // 1: client 1 wins a tie, 0: client 0 wins a tie
  logic                r_grant0;
  logic                r_grant1;
  logic                r_done0;
  logic                r_done1;
  logic                r_busy;

  logic                w_any_req;
  logic                w_win;
  logic [2*SIZE-1:0]   w_acc_next;

  assign w_any_req = bus.req0 | bus.req1;

  // A lone requester always wins; on a tie the pointer picks the client
  // that was not served most recently.
  assign w_win = (bus.req0 && bus.req1) ? r_rr : bus.req1;

  // One shift-add step; the sum wraps at 2*SIZE bits, which unsigned
  // SIZE x SIZE products never exceed.
  assign w_acc_next = r_temp_b[0] ? (r_acc + r_temp_a) : r_acc;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_temp_a  <= '0;
      r_temp_b  <= '0;
      r_acc     <= '0;
      r_outcome <= '0;
      r_cnt     <= '0;
      r_owner   <= 1'b0;
      r_rr      <= 1'b0;
      r_grant0  <= 1'b0;
      r_grant1  <= 1'b0;
      r_done0   <= 1'b0;
      r_done1   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      // grant/done are single-cycle pulses unless re-armed below.
      r_grant0 <= 1'b0;
      r_grant1 <= 1'b0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            // Operands are sampled only here; later input changes are invisible.
            r_temp_a <= {{SIZE{1'b0}}, (w_win ? bus.a1 : bus.a0)};
            r_temp_b <= w_win ? bus.b1 : bus.b0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_owner  <= w_win;
            r_rr     <= ~w_win;
            r_grant0 <= ~w_win;
            r_grant1 <= w_win;
            r_busy   <= 1'b1;
            r_state  <= S_CALC;
          end
        end

        S_CALC: begin
          r_acc    <= w_acc_next;
          r_temp_a <= r_temp_a << 1;
          r_temp_b <= r_temp_b >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == LAST_CNT) begin
            // Publish the sum including this edge's addition.
            r_outcome <= w_acc_next;
            r_done0   <= ~r_owner;
            r_done1   <= r_owner;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.grant0  = r_grant0;
  assign bus.grant1  = r_grant1;
  assign bus.done0   = r_done0;
  assign bus.done1   = r_done1;
  assign bus.outcome = r_outcome;
  assign bus.busy    = r_busy;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Purpose: directed self-checking bench for mult_share_ctrl.
// Latency: checks grant one cycle after request, done SIZE cycles after grant.
// Backpressure: clients drop req on the cycle grant is seen unless a test holds it.
module tb_mult_share_ctrl;

  localparam int SIZE = 8;
  localparam int CW   = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  mult_share_ctrl_if #(.SIZE(SIZE)) bus ();

  mult_share_ctrl #(.SIZE(SIZE), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Runs one job for a single client and checks latency, busy span, held
  // outcome, the product and that the other client sees nothing.
  task automatic run_job(input string tag, input bit cl,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp, input bit chg);
    int          k;
    bit          got;
    int          busy_n;
    int          other;
    int          held_bad;
    logic [15:0] prev;
    prev = bus.outcome;
    if (cl == 1'b0) begin
      bus.a0 = a; bus.b0 = b; bus.req0 = 1'b1;
    end else begin
      bus.a1 = a; bus.b1 = b; bus.req1 = 1'b1;
    end
    k = 0; got = 1'b0; other = 0;
    while (!got && k < 20) begin
      @(negedge clk);
      k++;
      got = cl ? bus.grant1 : bus.grant0;
      other += cl ? int'(bus.grant0 | bus.done0) : int'(bus.grant1 | bus.done1);
    end
    chk({tag, "_grant_lat"}, k, 1);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    if (chg) begin
      if (cl == 1'b0) begin bus.a0 = 8'd1; bus.b0 = 8'd1; end
      else begin bus.a1 = 8'd1; bus.b1 = 8'd1; end
    end
    busy_n = int'(bus.busy);
    k = 0; got = 1'b0; held_bad = 0;
    while (!got && k < 20) begin
      @(negedge clk);
      k++;
      got = cl ? bus.done1 : bus.done0;
      other += cl ? int'(bus.grant0 | bus.done0) : int'(bus.grant1 | bus.done1);
      if (!got) begin
        busy_n += int'(bus.busy);
        if (bus.outcome !== prev) held_bad++;
      end
    end
    chk({tag, "_done_lat"}, k, SIZE);
    chk({tag, "_busy_cycles"}, busy_n, SIZE);
    chk({tag, "_busy_at_done"}, bus.busy, 0);
    chk({tag, "_outcome"}, bus.outcome, exp);
    chk({tag, "_prev_held"}, held_bad, 0);
    chk({tag, "_other_client"}, other, 0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {bus.done1, bus.done0}, 0);
  endtask

  initial begin
    int gcl[4];
    int gcyc[4];
    int ng;
    int nd;
    int cyc;
    int bad_pair;
    int k;
    bit seen;

    n_checks = 0;
    n_errors = 0;
    reset    = 1'b0;
    bus.req0 = 1'b0; bus.a0 = '0; bus.b0 = '0;
    bus.req1 = 1'b0; bus.a1 = '0; bus.b1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_grant", {bus.grant1, bus.grant0}, 0);
    chk("rst_done", {bus.done1, bus.done0}, 0);
    chk("rst_outcome", bus.outcome, 0);
    chk("rst_busy", bus.busy, 0);
    reset = 1'b1;
    @(negedge clk);

    run_job("c0_13x11", 1'b0, 8'd13, 8'd11, 16'd143, 1'b0);
    run_job("c1_255x255", 1'b1, 8'd255, 8'd255, 16'd65025, 1'b0);

    // Both clients held from reset: expect 0,1,0,1 every SIZE+1 cycles.
    reset = 1'b0;
    bus.a0 = 8'd3; bus.b0 = 8'd5; bus.a1 = 8'd7; bus.b1 = 8'd9;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    ng = 0; nd = 0; cyc = 0; bad_pair = 0;
    while (nd < 4 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if ((bus.grant0 & bus.grant1) | (bus.done0 & bus.done1) |
          (bus.grant0 & bus.done0) | (bus.grant1 & bus.done1)) bad_pair++;
      if ((bus.grant0 | bus.grant1) && ng < 4) begin
        gcl[ng]  = bus.grant1 ? 1 : 0;
        gcyc[ng] = cyc;
        ng++;
        if (ng == 4) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
      end
      if (bus.done0 | bus.done1) begin
        chk($sformatf("tie_done_client%0d", nd), bus.done1, nd % 2);
        chk($sformatf("tie_outcome%0d", nd), bus.outcome, (nd % 2) ? 63 : 15);
        nd++;
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    chk("tie_grants_seen", ng, 4);
    chk("tie_dones_seen", nd, 4);
    for (int i = 0; i < ng; i++) begin
      chk($sformatf("tie_order%0d", i), gcl[i], i % 2);
      if (i > 0) chk($sformatf("tie_spacing%0d", i), gcyc[i] - gcyc[i-1], SIZE + 1);
    end
    chk("tie_exclusive_pulses", bad_pair, 0);
    @(negedge clk);

    run_job("zero_a", 1'b0, 8'd0, 8'd200, 16'd0, 1'b0);
    run_job("zero_b", 1'b0, 8'd200, 8'd0, 16'd0, 1'b0);
    run_job("opchg", 1'b0, 8'd100, 8'd100, 16'd10000, 1'b1);

    // Second job aborted by reset in CALC cycle 4.
    bus.a0 = 8'd50; bus.b0 = 8'd60; bus.req0 = 1'b1;
    k = 0; seen = 1'b0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      seen = bus.grant0;
    end
    chk("abort_grant_seen", seen, 1);
    bus.req0 = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_outcome", bus.outcome, 0);
    chk("abort_busy", bus.busy, 0);
    seen = bus.done0;
    bus.a0 = 8'd2; bus.b0 = 8'd3; bus.a1 = 8'd4; bus.b1 = 8'd5;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    repeat (SIZE) begin
      @(negedge clk);
      seen = seen | bus.done0;
    end
    chk("abort_no_done", seen, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_fresh_tie", {bus.grant1, bus.grant0}, 2'b01);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    k = 0; seen = 1'b0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      seen = bus.done0;
    end
    chk("abort_fresh_outcome", bus.outcome, 6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mult_share_ctrl.md
Name: mult_share_ctrl

Overview:
- Sequencing controller and two-port arbiter for a shared SIZE×SIZE shift-add multiplier.
- The multiplier retires one multiplier bit per clock, so a product takes SIZE cycles.
- Accepts requests from two clients, arbitrates round-robin, latches the operands and runs the shift-add iterations.
- Returns the product with a one-cycle done pulse addressed to the winning client.

Parameters:
SIZE, 8, operand width in bits; product width is 2*SIZE; iteration count is SIZE.
CW, 4, iteration counter width; must satisfy 2^CW > SIZE.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous active-low reset
req0  input  1  client 0 request; level, held until grant0
a0  input  SIZE  client 0 multiplicand
b0  input  SIZE  client 0 multiplier
req1  input  1  client 1 request; level, held until grant1
a1  input  SIZE  client 1 multiplicand
b1  input  SIZE  client 1 multiplier
grant0  output  1  one-cycle pulse: client 0 operands captured
grant1  output  1  one-cycle pulse: client 1 operands captured
done0  output  1  one-cycle pulse: outcome valid for client 0
done1  output  1  one-cycle pulse: outcome valid for client 1
outcome  output  2*SIZE  product of the last completed job; held until the next completion
busy  output  1  high while in CALC

Behaviour:
- Clock and reset: single clock clk, rising edge. reset is synchronous, active-low, sampled at the edge.
- Reset values: state=IDLE, grant0/1=0, done0/1=0, outcome=0, busy=0, rr pointer favours client 0, internal registers=0.
- FSM states:
  - IDLE: busy=0.
  - CALC: busy=1.
- IDLE, edge with any req high:
  - Select the winner (see arbitration).
  - Latch temp_a = zero-extended a of the winner (2*SIZE bits) and temp_b = b of the winner.
  - Clear acc; set cnt=0; record owner.
  - Pulse grantN for the following cycle; go to CALC.
- IDLE, no req: remain in IDLE; outputs hold.
- CALC, each edge:
  - If temp_b LSB=1, acc = acc + temp_a, modulo 2^(2*SIZE). No overflow is possible for unsigned operands.
  - temp_a <<= 1; temp_b >>= 1; cnt++.
- CALC, edge where cnt = SIZE-1:
  - Load outcome with the final acc, including that edge's addition.
  - Pulse done(owner) for one cycle; go to IDLE; busy drops.
- Latency: if the accept edge is E0, then:
  - grant is high during cycle E0..E1.
  - done and the new outcome are visible after edge E_SIZE.
  - The earliest next accept is edge E_SIZE+1.
- Throughput: one product per SIZE+1 cycles under continuous requests.
- Arbitration:
  - Only one req high: that client wins.
  - Both high: the client not served most recently wins. The pointer updates on every accept.
  - After reset, client 0 wins a tie.
- Requests in CALC are ignored; no grant is issued. Held requests are arbitrated at the first IDLE edge.
- Operands are sampled only at the accept edge. Later changes to aN/bN do not affect the running job.
- A req still high after grant (on the IDLE edge following done) is treated as a new request. Clients must drop req in the cycle grant is seen if they want only one job.
- grant and done are never both high for the same client in the same cycle. At most one grant and at most one done are high in any cycle.
- Reset asserted mid-CALC: abort the job with no done pulse; outcome=0; pointer reset.
- Operand 0 on either side yields outcome 0 with normal latency. There is no early termination.

Test Plan:
- req0 alone with a0=13, b0=11 -> grant0 one cycle after the accept edge; done0 exactly 8 cycles after grant0; outcome=143; busy high 8 cycles.
- req1 alone with a1=255, b1=255 -> done1 with outcome=65025; done0 and grant0 stay 0.
- req0 and req1 both held high from reset, with a0=3,b0=5 and a1=7,b1=9 -> grants order 0,1,0,1. Outcomes alternate 15 (done0) and 63 (done1); 9 cycles between consecutive grants.
- a0=0, b0=200, then a0=200, b0=0 -> both done0 after 8 cycles with outcome=0; the previous outcome is held until each done.
- Start a0=100, b0=100; change a0/b0 to 1/1 during CALC -> outcome=10000. Assert reset at CALC cycle 4 in a second job -> no done0; outcome=0, busy=0 the next cycle; a fresh tie grants client 0 first.
